// File: rtl/lc3b_pkg.sv
// Shared LC-3b definitions: PCMUX encodings, fetch FSM states and the default reset PC.
package lc3b_pkg;

  localparam logic [1:0] PCMUX_PC2    = 2'b00;
  localparam logic [1:0] PCMUX_TARGET = 2'b01;
  localparam logic [1:0] PCMUX_TRAP   = 2'b10;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_HELD = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready handshake between the fetch stage and imem.
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/fetch_pc_sel.sv
// Combinational next-PC selection: PC+2 adder and MEM-stage redirect mux.
module fetch_pc_sel
  import lc3b_pkg::*;
(
  input  logic [15:0] pc,
  input  logic [1:0]  mem_pcmux,
  input  logic [15:0] target_pc,
  input  logic [15:0] trap_pc,
  output logic [15:0] pc_plus2,
  output logic        redirect,
  output logic [15:0] redirect_pc
);

  // The reserved encoding 11 behaves like PC+2, i.e. no redirect.
  always_comb begin
    pc_plus2    = pc + 16'd2;
    redirect    = 1'b0;
    redirect_pc = pc_plus2;
    case (mem_pcmux)
      PCMUX_TARGET: begin
        redirect    = 1'b1;
        redirect_pc = {target_pc[15:1], 1'b0};
      end
      PCMUX_TRAP: begin
        redirect    = 1'b1;
        redirect_pc = {trap_pc[15:1], 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// LC-3b fetch stage: PC, imem handshake, one-word holding buffer and DE latches.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import lc3b_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  fetch_stage_if.master      imem,
  input  logic               dep_stall,
  input  logic               mem_stall,
  input  logic               v_de_br_stall,
  input  logic               v_agex_br_stall,
  input  logic               v_mem_br_stall,
  input  logic [1:0]         mem_pcmux,
  input  logic [15:0]        target_pc,
  input  logic [15:0]        trap_pc,
  output logic [15:0]        de_npc,
  output logic [15:0]        de_ir,
  output logic               de_v,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_bubbles
);

  localparam logic [1:0] ST_REQ  = FETCH_REQ;
  localparam logic [1:0] ST_HELD = FETCH_HELD;
  localparam logic [1:0] ST_DROP = FETCH_DROP;

  logic [1:0]  state;
  logic [15:0] pc;
  logic [15:0] ibuf;
  logic [15:0] drop_addr;
  logic [15:0] pc_plus2;
  logic [15:0] redirect_pc;
  logic        redirect;
  logic        ld_de;
  logic        br_stall;
  logic        avail;
  logic        advance;
  logic [15:0] word;

  fetch_pc_sel u_pc_sel (
    .pc          (pc),
    .mem_pcmux   (mem_pcmux),
    .target_pc   (target_pc),
    .trap_pc     (trap_pc),
    .pc_plus2    (pc_plus2),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  assign ld_de    = ~(dep_stall | mem_stall);
  assign br_stall = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;
  assign avail    = (state == ST_HELD) | ((state == ST_REQ) & imem.imem_ready);
  assign word     = (state == ST_HELD) ? ibuf : imem.imem_rdata;
  assign advance  = avail & ld_de & ~br_stall;

  // Request is suppressed while reset is held so nothing is issued before PC is valid.
  assign imem.imem_req  = ~rst & (state != ST_HELD);
  assign imem.imem_addr = (state == ST_DROP) ? drop_addr : pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_REQ;
      pc        <= RESET_PC;
      ibuf      <= 16'h0000;
      drop_addr <= 16'h0000;
      de_v      <= 1'b0;
      de_ir     <= 16'h0000;
      de_npc    <= 16'h0000;
    end else if (redirect) begin
      pc <= redirect_pc;
      // An unanswered request must still be retired before the target is fetched.
      if (state == ST_DROP) begin
        state <= ST_DROP;
      end else if ((state == ST_REQ) && !imem.imem_ready) begin
        drop_addr <= pc;
        state     <= ST_DROP;
      end else begin
        state <= ST_REQ;
      end
      if (ld_de) de_v <= 1'b0;
    end else if (advance) begin
      de_ir  <= word;
      de_npc <= pc_plus2;
      de_v   <= 1'b1;
      pc     <= pc_plus2;
      state  <= ST_REQ;
    end else if (avail) begin
      if (state == ST_REQ) ibuf <= imem.imem_rdata;
      state <= ST_HELD;
      if (ld_de) de_v <= 1'b0;
    end else begin
      if ((state == ST_DROP) && imem.imem_ready) state <= ST_REQ;
      if (ld_de) de_v <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetched_cnt;
  logic [15:0] bubbles_cnt;
  logic        load_valid;

  assign load_valid = advance & ~redirect;

  // Every DE load counts as either a useful fetch or a bubble, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_cnt <= 16'h0000;
      bubbles_cnt <= 16'h0000;
    end else if (ld_de) begin
      if (load_valid) begin
        if (fetched_cnt != 16'hFFFF) fetched_cnt <= fetched_cnt + 16'd1;
      end else begin
        if (bubbles_cnt != 16'hFFFF) bubbles_cnt <= bubbles_cnt + 16'd1;
      end
    end
  end

  assign perf_fetched = fetched_cnt;
  assign perf_bubbles = bubbles_cnt;
`else
  assign perf_fetched = 16'h0000;
  assign perf_bubbles = 16'h0000;
`endif

endmodule
